// File: rtl/acc_seq_if.sv
// Instruction- and data-memory bus between the accumulator sequencer and its
// synchronous memories. Read data is returned the cycle after the strobe.
interface acc_seq_if #(
  parameter int PW = 6,
  parameter int DW = 4
);
  logic [PW-1:0] im_addr;
  logic          im_re;
  logic [7:0]    im_rdata;
  logic [DW-1:0] dm_addr;
  logic          dm_re;
  logic [7:0]    dm_rdata;
  logic          dm_we;
  logic [7:0]    dm_wdata;

  modport master (
    output im_addr, im_re, dm_addr, dm_re, dm_we, dm_wdata,
    input  im_rdata, dm_rdata
  );

  modport slave (
    input  im_addr, im_re, dm_addr, dm_re, dm_we, dm_wdata,
    output im_rdata, dm_rdata
  );
endinterface

// File: rtl/acc_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator ISA with
// run/step/halt control. All bus strobes are registered on state entry.
module acc_seq_ctrl #(
  parameter int PW = 6,
  parameter int DW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          step,
  acc_seq_if.master     bus,
  output logic [7:0]    acc,
  output logic [PW-1:0] pp,
  output logic          instr_done,
  output logic          halted
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT} state_t;

  localparam logic [2:0] OP_LD_D = 3'd1, OP_LD_M = 3'd2, OP_ST  = 3'd3,
                         OP_ADD  = 3'd4, OP_XOR  = 3'd5, OP_JMP = 3'd6,
                         OP_HALT = 3'd7;

  state_t        state;
  logic [7:0]    ir, acc_q, acc_nxt, dm_wdata_q;
  logic [PW-1:0] pp_q, pp_nxt, im_addr_q;
  logic [DW-1:0] dm_addr_q;
  logic          armed, im_re_q, dm_re_q, dm_we_q, done_q, halt_q;
  logic [2:0]    op, dec_op;
  logic [7:0]    imm;
  logic          dec_mem;

  assign op      = ir[7:5];
  assign imm     = {{3{ir[4]}}, ir[4:0]};
  assign dec_op  = bus.im_rdata[7:5];
  assign dec_mem = (dec_op == OP_LD_M) || (dec_op == OP_ADD) || (dec_op == OP_XOR);
  assign pp_nxt  = (op == OP_JMP) ? imm[PW-1:0] : pp_q + 1'b1;

  always_comb begin
    acc_nxt = acc_q;
    case (op)
      OP_LD_D: acc_nxt = imm;
      OP_LD_M: acc_nxt = bus.dm_rdata;
      OP_ADD:  acc_nxt = acc_q + bus.dm_rdata;
      OP_XOR:  acc_nxt = acc_q ^ bus.dm_rdata;
      default: acc_nxt = acc_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      ir         <= '0;
      acc_q      <= '0;
      pp_q       <= '0;
      armed      <= 1'b0;
      im_re_q    <= 1'b0;
      im_addr_q  <= '0;
      dm_re_q    <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      done_q     <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      im_re_q <= 1'b0;
      dm_re_q <= 1'b0;
      dm_we_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: if (run || step) begin
          state     <= S_FETCH;
          armed     <= !run;
          im_re_q   <= 1'b1;
          im_addr_q <= pp_q;
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= bus.im_rdata;
          if (dec_mem) begin
            state     <= S_MEM;
            dm_re_q   <= 1'b1;
            dm_addr_q <= bus.im_rdata[DW-1:0];
          end else begin
            state  <= S_EXEC;
            done_q <= 1'b1;
            if (dec_op == OP_ST) begin
              dm_we_q    <= 1'b1;
              dm_addr_q  <= bus.im_rdata[DW-1:0];
              dm_wdata_q <= acc_q;
            end
          end
        end
        S_MEM: begin
          state  <= S_EXEC;
          done_q <= 1'b1;
        end
        S_EXEC: begin
          acc_q <= acc_nxt;
          if (op == OP_HALT) begin
            state  <= S_HALT;
            halt_q <= 1'b1;
          end else begin
            pp_q  <= pp_nxt;
            armed <= 1'b0;
            if (run && !armed) begin
              state     <= S_FETCH;
              im_re_q   <= 1'b1;
              im_addr_q <= pp_nxt;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // A store already registered for the EXEC cycle must not reach DM if reset lands on it.
  assign bus.dm_we    = dm_we_q & ~reset;
  assign bus.im_re    = im_re_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.dm_re    = dm_re_q;
  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_wdata = dm_wdata_q;
  assign acc          = acc_q;
  assign pp           = pp_q;
  assign instr_done   = done_q;
  assign halted       = halt_q;

endmodule
